// File: rtl/bram_bus_bridge_pkg.sv
// bram_bus_bridge_pkg
//   Shared definitions for the block-RAM bus bridge and the memory-window
//   decoder: FSM state encoding, bytes per RAM word and the address-window
//   mask helper.
package bram_bus_bridge_pkg;

  // 2-bit state encoding; RD_WAIT2 is only reachable in the output-register build.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_WAIT  = 2'd1,
    ST_RD_WAIT2 = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam int unsigned WORD_BYTES = 4;

  // Mask selecting the address bits above a window of WORD_BYTES << width bytes.
  // When the window spans the whole 32-bit space the shift wraps to 0 and the
  // mask becomes 0, which makes every address a hit.
  function automatic logic [31:0] window_mask(input int unsigned width);
    logic [31:0] win_bytes;
    win_bytes = 32'(WORD_BYTES) << width;
    return ~(win_bytes - 32'd1);
  endfunction

endpackage

// File: rtl/bram_window_decode.sv
// bram_window_decode
//   Combinational address-window decoder for memory-mapped slaves.
//   Ports:
//     addr_i      in  32     byte address
//     hit_o       out 1      address lies inside [BASE_ADDR, BASE_ADDR + 4<<WIDTH)
//     word_addr_o out WIDTH  word index inside the window (addr_i[WIDTH+1:2])
//   The two byte-offset bits never affect the hit decision.
module bram_window_decode
  import bram_bus_bridge_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic [31:0]      addr_i,
  output logic             hit_o,
  output logic [WIDTH-1:0] word_addr_o
);

  assign hit_o       = ((addr_i & window_mask(WIDTH)) == BASE_ADDR);
  assign word_addr_o = addr_i[WIDTH+1:2];

endmodule

// File: rtl/bram_bus_bridge.sv
// bram_bus_bridge
//   Adapts the core's native valid/ready memory bus to a single-port block RAM
//   (32-bit words, per-byte write mask, registered read). Out-of-window
//   accesses complete with mem_fault and are logged in a sticky fault register.
//
//   Handshake: the master raises mem_valid with stable mem_addr/mem_wdata/
//   mem_wstrb and holds them until it sees mem_ready. The bridge accepts only
//   in IDLE, and mem_ready is a single-cycle pulse in DONE; mem_rdata and
//   mem_fault are meaningful only while mem_ready is high. A request still
//   held during DONE is accepted in the following IDLE cycle.
//
//   Ports:
//     clk, resetn             clock, synchronous active-low reset
//     mem_valid/mem_ready     request / one-cycle completion
//     mem_addr/wdata/wstrb    byte address, write data, strobes (0 = read)
//     mem_rdata, mem_fault    response data, out-of-window flag
//     bram_addr/wdata/wmask   RAM word address, write data, byte enables
//     bram_rdata              RAM read data
//     fault_addr/pending      sticky first-fault address and flag
//     fault_clr               clears the sticky fault register (wins over a new miss)
//     dbg_state               current FSM state
//
//   Build option: define BRAM_BUS_BRIDGE_OUTREG_EN for RAMs with an extra
//   output register (adds RD_WAIT2, read latency 3).
module bram_bus_bridge
  import bram_bus_bridge_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_rdata,
  output logic             mem_fault,
  output logic [WIDTH-1:0] bram_addr,
  output logic [31:0]      bram_wdata,
  output logic [3:0]       bram_wmask,
  input  logic [31:0]      bram_rdata,
  output logic [31:0]      fault_addr,
  output logic             fault_pending,
  input  logic             fault_clr,
  output state_t           dbg_state
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             miss_q, miss_d;
  logic             fpend_q, fpend_d;
  logic [31:0]      faddr_q, faddr_d;

  logic             hit;
  logic [WIDTH-1:0] word_addr;
  logic             accept;

  bram_window_decode #(
    .WIDTH     (WIDTH),
    .BASE_ADDR (BASE_ADDR)
  ) u_decode (
    .addr_i      (mem_addr),
    .hit_o       (hit),
    .word_addr_o (word_addr)
  );

  assign accept = (state_q == ST_IDLE) && mem_valid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rdata_q <= '0;
      miss_q  <= 1'b0;
      fpend_q <= 1'b0;
      faddr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      miss_q  <= miss_d;
      fpend_q <= fpend_d;
      faddr_q <= faddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    miss_d  = miss_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_valid) begin
          addr_d  = word_addr;
          rdata_d = '0;          // writes and misses return zero data
          miss_d  = !hit;
          state_d = (hit && (mem_wstrb == 4'd0)) ? ST_RD_WAIT : ST_DONE;
        end
      end
      ST_RD_WAIT: begin
`ifdef BRAM_BUS_BRIDGE_OUTREG_EN
        state_d = ST_RD_WAIT2;
`else
        rdata_d = bram_rdata;
        state_d = ST_DONE;
`endif
      end
      ST_RD_WAIT2: begin
`ifdef BRAM_BUS_BRIDGE_OUTREG_EN
        rdata_d = bram_rdata;
        state_d = ST_DONE;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky fault log: only the first unserviced miss is kept; a clear in the
  // same cycle as a new miss drops that miss.
  always_comb begin
    fpend_d = fpend_q;
    faddr_d = faddr_q;
    if (fault_clr) begin
      fpend_d = 1'b0;
      faddr_d = '0;
    end else if (accept && !hit && !fpend_q) begin
      fpend_d = 1'b1;
      faddr_d = mem_addr;
    end
  end

  // The RAM has no enable, so the mask must be nonzero only in the accept cycle
  // and is forced low during reset.
  assign bram_wmask = (resetn && accept && hit) ? mem_wstrb : 4'd0;
  assign bram_addr  = (state_q == ST_IDLE) ? word_addr : addr_q;
  assign bram_wdata = mem_wdata;

  assign mem_ready     = (state_q == ST_DONE);
  assign mem_fault     = (state_q == ST_DONE) && miss_q;
  assign mem_rdata     = rdata_q;
  assign fault_pending = fpend_q;
  assign fault_addr    = faddr_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_bram_bus_bridge.sv
module tb_bram_bus_bridge;
  import bram_bus_bridge_pkg::*;

  localparam int unsigned W        = 6;
  localparam logic [31:0] BASE     = 32'h0000_1000;
  localparam logic [31:0] WIN      = 32'd4 << W;
`ifdef BRAM_BUS_BRIDGE_OUTREG_EN
  localparam int RL = 3;
`else
  localparam int RL = 2;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic          mem_valid;
  logic          mem_ready;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_rdata;
  logic          mem_fault;
  logic [W-1:0]  bram_addr;
  logic [31:0]   bram_wdata;
  logic [3:0]    bram_wmask;
  logic [31:0]   bram_rdata;
  logic [31:0]   fault_addr;
  logic          fault_pending;
  logic          fault_clr;
  state_t        dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  bram_bus_bridge #(.WIDTH(W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_fault(mem_fault),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_wmask(bram_wmask),
    .bram_rdata(bram_rdata),
    .fault_addr(fault_addr), .fault_pending(fault_pending), .fault_clr(fault_clr),
    .dbg_state(dbg_state)
  );

  // ---------------- block RAM model ----------------
  logic        ram_clr;
  logic [31:0] ram [64];
  logic [31:0] ram_q, ram_q2;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bram_wmask[b]) ram[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
    end
    ram_q  <= ram[bram_addr];
    ram_q2 <= ram_q;
  end
`ifdef BRAM_BUS_BRIDGE_OUTREG_EN
  assign bram_rdata = ram_q2;
`else
  assign bram_rdata = ram_q;
`endif

  // ---------------- monitors ----------------
  int cyc;
  int pulse_cyc[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mem_ready === 1'b1) pulse_cyc.push_back(cyc);

  // mem_valid must stay high until mem_ready has been seen.
  logic pv = 1'b0, pr = 1'b0;
  int   proto_errs = 0;
  always @(posedge clk) begin
    if (resetn && pv && !pr && !mem_valid) begin
      proto_errs <= proto_errs + 1;
      $display("protocol violation: mem_valid dropped before mem_ready at cycle %0d", cyc);
    end
    pv <= mem_valid && resetn;
    pr <= mem_ready;
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [int];
  logic        ref_pend  = 1'b0;
  logic [31:0] ref_faddr = 32'h0;

  task automatic ref_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] e_rd, output logic e_flt, output int e_lat);
    int idx;
    logic [31:0] old;
    if (a < BASE || a >= BASE + WIN) begin
      e_rd = 32'h0; e_flt = 1'b1; e_lat = 1;
      if (!ref_pend) begin ref_pend = 1'b1; ref_faddr = a; end
    end else begin
      idx = int'((a - BASE) / 4);
      old = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
      e_flt = 1'b0;
      if (s == 4'h0) begin
        e_rd = old; e_lat = RL;
      end else begin
        for (int b = 0; b < 4; b++) if (s[b]) old[8*b +: 8] = d[8*b +: 8];
        ref_mem[idx] = old;
        e_rd = 32'h0; e_lat = 1;
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the edge ending DONE.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input bit keep, output logic [31:0] rd, output logic flt,
                         output int lat, output int wm_n, output logic [3:0] wm_v);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    rd = 32'h0; flt = 1'b0; lat = -1; wm_n = 0; wm_v = 4'h0;
    for (int c = 0; c < 12 && lat < 0; c++) begin
      @(negedge clk);
      if (bram_wmask != 4'h0) begin wm_n++; wm_v = bram_wmask; end
      if (mem_ready) begin lat = c; rd = mem_rdata; flt = mem_fault; end
      @(posedge clk); #1;
    end
    if (!keep) begin mem_valid = 1'b0; mem_wstrb = 4'h0; end
  endtask

  task automatic do_check(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit keep, input logic [31:0] e_rd,
                          input logic e_flt, input int e_lat);
    logic [31:0] rd; logic flt; int lat, wm_n; logic [3:0] wm_v; int e_wm;
    exp_q.push_back(e_rd);
    run_txn(a, d, s, keep, rd, flt, lat, wm_n, wm_v);
    chk({tag, " rdata"}, rd, exp_q.pop_front());
    chk({tag, " fault"}, 32'(flt), 32'(e_flt));
    chk({tag, " latency"}, lat, e_lat);
    e_wm = (s != 4'h0 && !e_flt) ? 1 : 0;
    chk({tag, " wmask cycles"}, wm_n, e_wm);
    if (e_wm == 1) chk({tag, " wmask value"}, 32'(wm_v), 32'(s));
  endtask

  task automatic model_check(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input bit keep);
    logic [31:0] e_rd; logic e_flt; int e_lat;
    ref_txn(a, d, s, e_rd, e_flt, e_lat);
    do_check(tag, a, d, s, keep, e_rd, e_flt, e_lat);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    int          exp_lat;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    logic [31:0] e_rd; logic e_flt; int e_lat;
    int p0;
    logic [31:0] a;
    logic [3:0]  s;

    vecs[0] = '{BASE + 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,         1'b0, 1};
    vecs[1] = '{BASE + 32'h10, 32'h0,        4'h0, 32'hDEADBEEF,  1'b0, RL};
    vecs[2] = '{BASE + 32'h20, 32'h11223344, 4'hF, 32'h0,         1'b0, 1};
    vecs[3] = '{BASE + 32'h20, 32'h000000AA, 4'h1, 32'h0,         1'b0, 1};
    vecs[4] = '{BASE + 32'h20, 32'h0,        4'h0, 32'h112233AA,  1'b0, RL};
    vecs[5] = '{BASE + 32'h22, 32'h0,        4'h0, 32'h112233AA,  1'b0, RL};
    vecs[6] = '{BASE + 32'hFC, 32'hCAFEF00D, 4'hA, 32'h0,         1'b0, 1};
    vecs[7] = '{BASE + 32'hFC, 32'h0,        4'h0, 32'hCA00F000,  1'b0, RL};
    vecs[8] = '{BASE - 32'h4,  32'h12345678, 4'hF, 32'h0,         1'b1, 1};

    // Reset with a write request held: no mask may reach the RAM.
    resetn = 1'b0; fault_clr = 1'b0; ram_clr = 1'b1;
    mem_valid = 1'b1; mem_addr = BASE + 32'h10; mem_wdata = 32'h55AA55AA; mem_wstrb = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("wmask during reset", 32'(bram_wmask), 32'h0);
    chk("ready during reset", 32'(mem_ready), 32'h0);
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_wstrb = 4'h0; ram_clr = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("reset ready", 32'(mem_ready), 32'h0);
    chk("reset fault", 32'(mem_fault), 32'h0);
    chk("reset rdata", mem_rdata, 32'h0);
    chk("reset fault_pending", 32'(fault_pending), 32'h0);
    chk("reset fault_addr", fault_addr, 32'h0);
    chk("reset state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;

    // Table-driven vectors; the model is kept in step for later phases.
    for (int i = 0; i < 9; i++) begin
      ref_txn(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, e_rd, e_flt, e_lat);
      do_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 1'b0,
               vecs[i].exp_rdata, vecs[i].exp_fault, vecs[i].exp_lat);
    end
    chk("vec fault_addr", fault_addr, BASE - 32'h4);

    // Sticky fault register.
    fault_clr = 1'b1; @(posedge clk); #1; fault_clr = 1'b0;
    ref_pend = 1'b0; ref_faddr = 32'h0;
    chk("clear pending", 32'(fault_pending), 32'h0);
    model_check("miss1", BASE + WIN, 32'hFFFFFFFF, 4'hF, 1'b0);
    chk("miss1 pending", 32'(fault_pending), 32'h1);
    chk("miss1 fault_addr", fault_addr, BASE + WIN);
    model_check("miss2", 32'h0000_2000, 32'h0, 4'h0, 1'b0);
    chk("miss2 fault_addr kept", fault_addr, BASE + WIN);
    fault_clr = 1'b1; @(posedge clk); #1; fault_clr = 1'b0;
    ref_pend = 1'b0; ref_faddr = 32'h0;
    chk("clr pending", 32'(fault_pending), 32'h0);
    chk("clr fault_addr", fault_addr, 32'h0);
    // Clear held across a new miss: the clear wins.
    fault_clr = 1'b1;
    do_check("miss_vs_clr", 32'h0000_3000, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 1);
    fault_clr = 1'b0;
    chk("miss_vs_clr pending", 32'(fault_pending), 32'h0);
    chk("miss_vs_clr fault_addr", fault_addr, 32'h0);

    // Back-to-back reads held continuously.
    p0 = pulse_cyc.size();
    model_check("b2b0", BASE + 32'h10, 32'h0, 4'h0, 1'b1);
    model_check("b2b1", BASE + 32'h20, 32'h0, 4'h0, 1'b1);
    model_check("b2b2", BASE + 32'hFC, 32'h0, 4'h0, 1'b1);
    model_check("b2b3", BASE + 32'h40, 32'h0, 4'h0, 1'b0);
    chk("b2b pulse count", pulse_cyc.size() - p0, 4);
    if (pulse_cyc.size() - p0 == 4)
      for (int i = 1; i < 4; i++)
        chk($sformatf("b2b spacing%0d", i), pulse_cyc[p0+i] - pulse_cyc[p0+i-1], RL + 1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = BASE + WIN + $urandom_range(0, 63);
        default: a = BASE + $urandom_range(0, WIN - 1);
      endcase
      s = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      model_check($sformatf("rnd%0d", i), a, $urandom, s, 1'b0);
      chk($sformatf("rnd%0d pending", i), 32'(fault_pending), 32'(ref_pend));
      chk($sformatf("rnd%0d fault_addr", i), fault_addr, ref_faddr);
    end

    // Reset while a read waits on the RAM.
    model_check("pre_rst_wr", BASE + 32'h10, 32'h5A5A5A5A, 4'hF, 1'b0);
    model_check("pre_rst_rd", BASE + 32'h10, 32'h0, 4'h0, 1'b0);
    mem_valid = 1'b1; mem_addr = BASE + 32'h10; mem_wstrb = 4'h0;
    @(posedge clk); #1;
    chk("rst_mid state", 32'(dbg_state), 32'(ST_RD_WAIT));
    p0 = pulse_cyc.size();
    resetn = 1'b0; mem_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    ref_pend = 1'b0; ref_faddr = 32'h0;
    @(negedge clk);
    chk("rst_mid ready", 32'(mem_ready), 32'h0);
    chk("rst_mid rdata", mem_rdata, 32'h0);
    chk("rst_mid fault", 32'(mem_fault), 32'h0);
    chk("rst_mid pending", 32'(fault_pending), 32'h0);
    chk("rst_mid fault_addr", fault_addr, 32'h0);
    chk("rst_mid state idle", 32'(dbg_state), 32'(ST_IDLE));
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid no pulse", pulse_cyc.size() - p0, 0);
    model_check("post_rst_rd", BASE + 32'h10, 32'h0, 4'h0, 1'b0);
    model_check("post_rst_wr", BASE + 32'h14, 32'h0BADF00D, 4'hF, 1'b0);

    chk("protocol", proto_errs, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
